// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Merges NCH sram-like masters (req / addr_ok / data_ok) onto a single
// downstream sram-like port. Requests are muxed combinationally from the
// granted channel (zero added latency). Every accepted downstream request
// pushes the granted channel index into an outstanding-ID FIFO. Responses come
// back in order, so the FIFO head tells which channel gets ch_data_ok.
//
// Configuration macro:
//   SRAM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                           undefined -> round-robin (default build)
//
// Parameters:
//   NCH      number of upstream channels (2..8)
//   AW / DW  address / data width (strobe width DW/8)
//   MAX_OUT  outstanding downstream transactions (power of two, 2..16)
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   ch_req/ch_wr     per-channel request and write flag (bit i = channel i)
//   ch_size          per-channel size, channel i at [2i+1:2i]
//   ch_wstrb/ch_addr/ch_wdata  per-channel packed strobes/address/write data
//   ch_addr_ok       per-channel request accept
//   ch_data_ok       per-channel response valid
//   ch_rdata         downstream read data broadcast to all channels
//   m_*              downstream sram-like port
//   outstanding      entries currently held in the ID FIFO
//   err_orphan       sticky: a response arrived with the ID FIFO empty
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH-1:0]            ch_wr,
  input  logic [2*NCH-1:0]          ch_size,
  input  logic [NCH*(DW/8)-1:0]     ch_wstrb,
  input  logic [NCH*AW-1:0]         ch_addr,
  input  logic [NCH*DW-1:0]         ch_wdata,
  output logic [NCH-1:0]            ch_addr_ok,
  output logic [NCH-1:0]            ch_data_ok,
  output logic [DW-1:0]             ch_rdata,
  output logic                      m_req,
  output logic                      m_wr,
  output logic [1:0]                m_size,
  output logic [DW/8-1:0]           m_wstrb,
  output logic [AW-1:0]             m_addr,
  output logic [DW-1:0]             m_wdata,
  input  logic                      m_addr_ok,
  input  logic                      m_data_ok,
  input  logic [DW-1:0]             m_rdata,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic                      err_orphan
);

  localparam int IW = $clog2(NCH);
  localparam int PW = $clog2(MAX_OUT);
  localparam int SW = DW / 8;

  // Unpacked views of the per-channel request fields
  logic          w_ch_wr    [NCH];
  logic [1:0]    w_ch_size  [NCH];
  logic [SW-1:0] w_ch_wstrb [NCH];
  logic [AW-1:0] w_ch_addr  [NCH];
  logic [DW-1:0] w_ch_wdata [NCH];

  // Lock and ID FIFO state
  logic          r_lock;
  logic [IW-1:0] r_lock_id;
  logic [IW-1:0] r_id_mem [MAX_OUT];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_err_orphan;

  logic          w_lock_hold;
  logic [IW-1:0] w_arb_grant;
  logic          w_arb_found;
  logic [IW-1:0] w_grant;
  logic          w_full;
  logic          w_empty;
  logic          w_handshake;
  logic          w_pop;
  logic [IW-1:0] w_head_id;

  // ---------------------------------------------------------------------------
  // Channel unpacking and per-channel accept/response decode
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_ch_wr[gi]    = ch_wr[gi];
    assign w_ch_size[gi]  = ch_size[2*gi +: 2];
    assign w_ch_wstrb[gi] = ch_wstrb[SW*gi +: SW];
    assign w_ch_addr[gi]  = ch_addr[AW*gi +: AW];
    assign w_ch_wdata[gi] = ch_wdata[DW*gi +: DW];

    assign ch_addr_ok[gi] = w_handshake & (w_grant == IW'(gi));
    assign ch_data_ok[gi] = w_pop & (w_head_id == IW'(gi));
  end

  // ---------------------------------------------------------------------------
  // Arbitration (lock-free choice)
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_arb_grant = '0;
    w_arb_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_arb_found && ch_req[k]) begin
        w_arb_grant = IW'(k);
        w_arb_found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] r_rr;
  logic [IW:0]   w_idx;

  // First requesting channel at or after r_rr, wrapping modulo NCH
  // (NCH need not be a power of two, so wrap explicitly).
  always_comb begin
    w_arb_grant = r_rr;
    w_arb_found = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = {1'b0, r_rr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NCH)) begin
        w_idx = w_idx - (IW+1)'(NCH);
      end
      if (!w_arb_found && ch_req[w_idx[IW-1:0]]) begin
        w_arb_grant = w_idx[IW-1:0];
        w_arb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (w_handshake) begin
      r_rr <= (w_grant == IW'(NCH-1)) ? '0 : w_grant + 1'b1;
    end
  end
`endif

  // A held lock pins the grant; if its owner drops req the lock is ignored
  // this cycle so arbitration reruns immediately.
  assign w_lock_hold = r_lock & ch_req[r_lock_id];
  assign w_grant     = w_lock_hold ? r_lock_id : w_arb_grant;

  // ---------------------------------------------------------------------------
  // Downstream request path (combinational, zero latency)
  // ---------------------------------------------------------------------------
  // w_full comes from the registered count only, so m_data_ok never reaches
  // m_req combinationally (a pop frees a slot on the following cycle).
  assign w_full      = (r_count == (PW+1)'(MAX_OUT));
  assign w_empty     = (r_count == '0);
  assign m_req       = ch_req[w_grant] & ~w_full & ~reset;
  assign w_handshake = m_req & m_addr_ok;

  assign m_wr    = w_ch_wr[w_grant];
  assign m_size  = w_ch_size[w_grant];
  assign m_wstrb = w_ch_wstrb[w_grant];
  assign m_addr  = w_ch_addr[w_grant];
  assign m_wdata = w_ch_wdata[w_grant];

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  assign w_pop     = m_data_ok & ~w_empty;
  assign w_head_id = r_id_mem[r_head];
  assign ch_rdata  = m_rdata;

  // ID storage has no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_handshake) begin
      r_id_mem[r_tail] <= w_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
      r_lock       <= 1'b0;
      r_lock_id    <= '0;
    end else begin
      if (w_handshake) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      // Push and pop together leave the count unchanged.
      if (w_handshake && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_handshake && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (m_data_ok && w_empty) begin
        r_err_orphan <= 1'b1;
      end
      // Lock while a request is presented but not yet accepted.
      r_lock    <= m_req & ~m_addr_ok;
      r_lock_id <= w_grant;
    end
  end

  assign outstanding = r_count;
  assign err_orphan  = r_err_orphan;

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter merging several sram-like masters (req/addr_ok/data_ok) onto one downstream sram-like port, with in-order response routing through an outstanding-ID FIFO. It sits between the CPU core's inst/data sram-like interfaces, plus any future requesters such as a page-table walker or cache refill, and the single bridge toward the system bus. It adds zero cycles of latency on the request and response paths.

## Interface
- NCH, 2: number of upstream channels (2..8); channel 0 is the lowest index.
- AW, 32: address width.
- DW, 32: data width; strobe width is DW/8.
- MAX_OUT, 4: maximum outstanding downstream transactions (power of two, 2..16).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- ch_req  in  NCH  per-channel request.
- ch_wr  in  NCH  per-channel write flag.
- ch_size  in  2*NCH  per-channel size; channel i occupies bits [2i+1:2i].
- ch_wstrb  in  NCH*DW/8  per-channel byte strobes.
- ch_addr  in  NCH*AW  per-channel address.
- ch_wdata  in  NCH*DW  per-channel write data.
- ch_addr_ok  out  NCH  per-channel address accept.
- ch_data_ok  out  NCH  per-channel response valid.
- ch_rdata  out  DW  read data, broadcast to all channels.
- m_req, m_wr  out  1  downstream request and write flag.
- m_size  out  2  downstream size.
- m_wstrb  out  DW/8  downstream byte strobes.
- m_addr  out  AW  downstream address.
- m_wdata  out  DW  downstream write data.
- m_addr_ok, m_data_ok  in  1  downstream accept and response.
- m_rdata  in  DW  downstream read data.
- outstanding  out  log2(MAX_OUT)+1  current number of entries in the ID FIFO.
- err_orphan  out  1  sticky flag: m_data_ok arrived while the ID FIFO was empty.

## Operation
- Grant g is the channel driving m_wr, m_size, m_wstrb, m_addr and m_wdata. These fields are muxed combinationally from channel g.
- m_req = ch_req[g] & ~full & ~reset.
- full = (outstanding == MAX_OUT). There is no bypass when a pop and a push would occur in the same cycle.
- Arbitration is round-robin. Pointer rr starts at 0. g is the first requesting channel at or after rr, modulo NCH.
  - After a handshake (m_req & m_addr_ok), rr <= g+1 mod NCH.
- Lock register: set when m_req & ~m_addr_ok, holding lock_id = g.
  - While the lock is set, g = lock_id regardless of rr and of other requests.
  - The lock clears on the handshake.
  - If ch_req[lock_id] drops (protocol violation), the lock clears and arbitration reruns in the same cycle.
- ch_addr_ok[i] = m_req & m_addr_ok & (g == i).
- Handshake pushes g into the ID FIFO (depth MAX_OUT, head/tail pointers wrap at MAX_OUT).
- ch_data_ok[i] = m_data_ok & ~empty & (head_id == i). m_data_ok pops the FIFO.
- ch_rdata = m_rdata, unconditionally.
- Simultaneous push and pop: outstanding is unchanged, and both pointers advance.
- m_data_ok while the FIFO is empty: the response is dropped, no ch_data_ok is raised, and err_orphan <= 1 until reset.

## Timing
- Request-to-downstream latency is 0 cycles (combinational). Response routing is also 0 cycles.
- A channel's fields must stay stable from ch_req until its ch_addr_ok. The arbiter guarantees g does not change while the lock is held.
- No combinational path from m_data_ok to m_req.
- Reset values:
  - outstanding = 0, err_orphan = 0, rr = 0, lock cleared.
  - m_req = 0 and ch_addr_ok = 0 while reset is high.
  - ch_data_ok = 0 after reset because the FIFO is empty.
- Reset mid-transaction: the FIFO, lock and rr are cleared in the reset cycle. Downstream responses arriving afterwards set err_orphan; the system bridge must be reset together with this block.
- Maximum throughput is one handshake per cycle with back-to-back grants to different channels.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. rr is not implemented. The lock behaviour is unchanged.
- SRAM_ARB_FIXED_PRIO_EN undefined: round-robin as described in Operation.

## Test plan
- NCH=2, MAX_OUT=4. ch0 and ch1 both request continuously, m_addr_ok=1 every cycle -> grants alternate 0,1,0,1. Responses returned in order raise ch_data_ok 0,1,0,1.
- ch1 requests with m_addr_ok held 0 for 3 cycles, and ch0 raises req in cycle 1 -> g stays 1 and m_addr stays ch1's address. ch1 gets ch_addr_ok in cycle 3, then ch0 is granted in cycle 4.
- Four reads accepted with no m_data_ok -> outstanding=4 and m_req=0 despite ch_req. One m_data_ok -> outstanding=3, and m_req rises the next cycle.
- Handshake and m_data_ok in the same cycle with outstanding=2 -> outstanding stays 2, and the head ID is routed correctly.
- m_data_ok with an empty FIFO -> no ch_data_ok, and err_orphan=1 until reset.
- Reset asserted with outstanding=3 -> the next cycle shows outstanding=0, err_orphan=0 and m_req=0. With SRAM_ARB_FIXED_PRIO_EN, continuous requests from both channels grant ch0 every cycle.
